// File: rtl/vme_cmd_sequencer.sv
// VME A24/D16 master sequencer: fetches one command per request, runs a single bus cycle, reports the result.
// Optional DTACK timeout is enabled by defining VME_SEQ_TIMEOUT_EN.
module vme_cmd_sequencer #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned GAP_CYC     = 4,
  parameter logic [5:0]  AM_CODE     = 6'h39
) (
  input  logic        clk,
  input  logic        rst,
  output logic        vme_cmd_rd,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic [31:0] vme_dat_reg_out,
  output logic        vme_dat_wr,
  output logic [23:0] vme_addr,
  output logic [5:0]  vme_am,
  output logic        vme_write_b,
  output logic        vme_as_b,
  output logic        vme_ds_b,
  output logic [15:0] vme_data_out,
  output logic        vme_data_oe,
  input  logic [15:0] vme_data_in,
  input  logic        vme_dtack_b,
  output logic        busy
);

  localparam int unsigned CNT_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int unsigned CNT_MAX = (CNT_SG > TIMEOUT_CYC) ? CNT_SG : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
`ifdef VME_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_REQ     = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RESP    = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      addr_l_q, addr_l_d;
  logic             wr_l_q, wr_l_d;
  logic [15:0]      wdata_l_q, wdata_l_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             bad_q, bad_d;
  logic             tmo_q, tmo_d;

  logic        cmd_rd_q, cmd_rd_d;
  logic        dat_wr_q, dat_wr_d;
  logic        busy_q, busy_d;
  logic [31:0] dat_out_q, dat_out_d;
  logic [23:0] addr_q, addr_d;
  logic [5:0]  am_q, am_d;
  logic        write_b_q, write_b_d;
  logic        as_b_q, as_b_d;
  logic        ds_b_q, ds_b_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;

  logic unused_bits_s;
  assign unused_bits_s = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

  // State, command latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_REQ;
      cnt_q     <= '0;
      addr_l_q  <= 24'd0;
      wr_l_q    <= 1'b0;
      wdata_l_q <= 16'd0;
      rdata_q   <= 16'd0;
      bad_q     <= 1'b0;
      tmo_q     <= 1'b0;
      cmd_rd_q  <= 1'b0;
      dat_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      dat_out_q <= 32'd0;
      addr_q    <= 24'd0;
      am_q      <= 6'd0;
      write_b_q <= 1'b1;
      as_b_q    <= 1'b1;
      ds_b_q    <= 1'b1;
      dout_q    <= 16'd0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_l_q  <= addr_l_d;
      wr_l_q    <= wr_l_d;
      wdata_l_q <= wdata_l_d;
      rdata_q   <= rdata_d;
      bad_q     <= bad_d;
      tmo_q     <= tmo_d;
      cmd_rd_q  <= cmd_rd_d;
      dat_wr_q  <= dat_wr_d;
      busy_q    <= busy_d;
      dat_out_q <= dat_out_d;
      addr_q    <= addr_d;
      am_q      <= am_d;
      write_b_q <= write_b_d;
      as_b_q    <= as_b_d;
      ds_b_q    <= ds_b_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
    end
  end

  // Next state, cycle counter and command/result latches
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_l_d  = addr_l_q;
    wr_l_d    = wr_l_q;
    wdata_l_d = wdata_l_q;
    rdata_d   = rdata_q;
    bad_d     = bad_q;
    tmo_d     = tmo_q;
    case (state_q)
      // REQ is left only once its request pulse has actually been driven (covers the cycle after reset)
      ST_REQ: begin
        if (cmd_rd_q) state_d = ST_WAIT;
        else          state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (start) begin
          addr_l_d  = vme_cmd_reg[23:0];
          wr_l_d    = vme_cmd_reg[24];
          wdata_l_d = vme_dat_reg_in[15:0];
          rdata_d   = 16'd0;
          tmo_d     = 1'b0;
          cnt_d     = '0;
          if (vme_cmd_reg[25] ^ vme_cmd_reg[24]) begin
            bad_d   = 1'b0;
            state_d = ST_SETUP;
          end else begin
            bad_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (!vme_dtack_b) begin
          if (!wr_l_q) rdata_d = vme_data_in;
          else         rdata_d = rdata_q;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
`ifdef VME_SEQ_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            rdata_d = 16'd0;
            state_d = ST_RESP;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
`else
          state_d = ST_STROBE;
`endif
        end
      end
      ST_RELEASE: begin
        if (vme_dtack_b) begin
          state_d = ST_RESP;
        end else begin
`ifdef VME_SEQ_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
`else
          state_d = ST_RELEASE;
`endif
        end
      end
      ST_RESP: begin
        cnt_d = '0;
        if (GAP_CYC == 0) state_d = ST_REQ;
        else              state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_REQ;
        else                   cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state
  always_comb begin
    cmd_rd_d  = (state_d == ST_REQ);
    busy_d    = (state_d != ST_REQ) && (state_d != ST_WAIT);
    dat_wr_d  = 1'b0;
    dat_out_d = dat_out_q;
    addr_d    = 24'd0;
    am_d      = 6'd0;
    write_b_d = 1'b1;
    as_b_d    = 1'b1;
    ds_b_d    = 1'b1;
    dout_d    = 16'd0;
    oe_d      = 1'b0;
    case (state_d)
      ST_SETUP, ST_STROBE, ST_RELEASE: begin
        addr_d    = addr_l_d;
        am_d      = AM_CODE;
        write_b_d = ~wr_l_d;
        if (wr_l_d) begin
          dout_d = wdata_l_d;
          oe_d   = 1'b1;
        end else begin
          dout_d = 16'd0;
          oe_d   = 1'b0;
        end
        if (state_d == ST_STROBE) begin
          as_b_d = 1'b0;
          ds_b_d = 1'b0;
        end else begin
          as_b_d = 1'b1;
          ds_b_d = 1'b1;
        end
      end
      ST_RESP: begin
        dat_wr_d  = 1'b1;
        dat_out_d = {tmo_d, bad_d, 14'd0, rdata_d};
      end
      default: dat_wr_d = 1'b0;
    endcase
  end

  assign vme_cmd_rd      = cmd_rd_q;
  assign vme_dat_wr      = dat_wr_q;
  assign busy            = busy_q;
  assign vme_dat_reg_out = dat_out_q;
  assign vme_addr        = addr_q;
  assign vme_am          = am_q;
  assign vme_write_b     = write_b_q;
  assign vme_as_b        = as_b_q;
  assign vme_ds_b        = ds_b_q;
  assign vme_data_out    = dout_q;
  assign vme_data_oe     = oe_q;

endmodule
